// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: FSM encoding, latency
// counter sizing and byte-lane helpers.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int CNT_W   = 4;
  localparam int LAT_MAX = 15;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int LANE0  = 0;  // bits [7:0]
  localparam int LANE1  = 1;
  localparam int LANE2  = 2;
  localparam int LANE3  = 3;  // bits [31:24]

  function automatic logic [31:0] lane_mask(input logic [LANES-1:0] en);
    logic [31:0] m;
    m = '0;
    for (int l = 0; l < LANES; l++) begin
      m[l*LANE_W +: LANE_W] = {LANE_W{en[l]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/data_mem_bank.sv
// Single-port byte-enabled word RAM with a registered read port. Contents are
// never reset; only the read register is.
module data_mem_bank
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic [LANES-1:0]      we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] wmask;

  assign wmask = lane_mask(we);

  always_ff @(posedge clock) begin
    if (en && (we != '0)) begin
      mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
    end
  end

  // A write cycle leaves rdata untouched so the last read result is held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (en && (we == '0)) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: captures a level-held read/write command, waits a
// fixed number of cycles, performs the access and pulses DataMem_Ready.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] MWriteData,
  input  logic [3:0]  WriteEnable,
  input  logic        ReadEnable,
  output logic [31:0] MReadData,
  output logic        DataMem_Ready,
  output logic        ProtocolErr,
  output state_e      fsm_state
);

  if (READ_LATENCY < 0 || READ_LATENCY > LAT_MAX ||
      WRITE_LATENCY < 0 || WRITE_LATENCY > LAT_MAX) begin : g_bad_latency
    $error("data_mem_responder: latency parameters must be within 0..15");
  end

  localparam logic [CNT_W-1:0] RD_LAT = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] WR_LAT = CNT_W'(WRITE_LATENCY);

  // Handshake: the requestor holds ReadEnable/WriteEnable level-high from
  // capture through the cycle DataMem_Ready is 1, and drops it (or issues the
  // next command) afterwards; commands are only sampled in IDLE.

  state_e                state, next_state;
  logic [CNT_W-1:0]      cnt, cap_lat;
  logic [ADDR_WIDTH-1:0] cmd_addr, lat_addr, bank_addr;
  logic [31:0]           lat_wdata, bank_wdata;
  logic [3:0]            lat_we, bank_we;
  logic                  cmd_write, capture, bank_en, err;
  logic                  unused_addr_bits;

  assign cmd_addr         = Address[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};
  assign cmd_write        = (WriteEnable != '0);
  assign capture          = (state == IDLE) && (ReadEnable || cmd_write);
  assign cap_lat          = cmd_write ? WR_LAT : RD_LAT;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= '0;
      err       <= 1'b0;
    end else if (capture) begin
      cnt       <= cap_lat;
      lat_addr  <= cmd_addr;
      lat_wdata <= MWriteData;
      lat_we    <= WriteEnable;
      if (ReadEnable && cmd_write) begin
        err <= 1'b1;
      end
    end else if (state == WAIT) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (capture) next_state = (cap_lat == '0) ? RESP : WAIT;
      WAIT: if (cnt == CNT_W'(1)) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The RAM is clocked on the edge that enters RESP so the registered read
  // word is already on MReadData during the Ready cycle. With zero latency
  // that edge is the capture edge, so the live command feeds the RAM.
  always_comb begin
    DataMem_Ready = (state == RESP);
    bank_en       = reset && (next_state == RESP);
    bank_addr     = lat_addr;
    bank_we       = lat_we;
    bank_wdata    = lat_wdata;
    if (state == IDLE) begin
      bank_addr  = cmd_addr;
      bank_we    = WriteEnable;
      bank_wdata = MWriteData;
    end
  end

  data_mem_bank #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bank (
    .clock(clock),
    .reset(reset),
    .en   (bank_en),
    .we   (bank_we),
    .addr (bank_addr),
    .wdata(bank_wdata),
    .rdata(MReadData)
  );

  assign ProtocolErr = err;
  assign fsm_state   = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances cover the default
// latencies, zero latency, and a long-latency reset-abort case.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic        clk;
  logic [2:0]  rst;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  we    [3];
  logic [2:0]  re;
  logic [31:0] rdata [3];
  logic [2:0]  rdy;
  logic [2:0]  perr;
  state_e      st    [3];

  int n_cmp  = 0;
  int n_fail = 0;

  data_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(2), .WRITE_LATENCY(1)) dut0 (
    .clock(clk), .reset(rst[0]), .Address(addr[0]), .MWriteData(wdata[0]),
    .WriteEnable(we[0]), .ReadEnable(re[0]), .MReadData(rdata[0]),
    .DataMem_Ready(rdy[0]), .ProtocolErr(perr[0]), .fsm_state(st[0]));

  data_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(0), .WRITE_LATENCY(0)) dut1 (
    .clock(clk), .reset(rst[1]), .Address(addr[1]), .MWriteData(wdata[1]),
    .WriteEnable(we[1]), .ReadEnable(re[1]), .MReadData(rdata[1]),
    .DataMem_Ready(rdy[1]), .ProtocolErr(perr[1]), .fsm_state(st[1]));

  data_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(4), .WRITE_LATENCY(4)) dut2 (
    .clock(clk), .reset(rst[2]), .Address(addr[2]), .MWriteData(wdata[2]),
    .WriteEnable(we[2]), .ReadEnable(re[2]), .MReadData(rdata[2]),
    .DataMem_Ready(rdy[2]), .ProtocolErr(perr[2]), .fsm_state(st[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    int          cycles;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives the command, waits for Ready (bounded),
  // checks latency, read data and error flag, then drops the command.
  task automatic do_access(input int i, input logic rd, input logic [3:0] w,
                           input logic [31:0] a, input logic [31:0] d,
                           input int exp_n, input logic [31:0] exp_rdata,
                           input logic exp_err, input string tag);
    int  n;
    bit  seen;
    addr[i]  = a;
    wdata[i] = d;
    we[i]    = w;
    re[i]    = rd;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (rdy[i]) seen = 1;
    end
    if (!seen) $display("FAIL %s timeout: got no ready expected ready", tag);
    check({tag, " latency"}, n, exp_n);
    check({tag, " rdata"}, rdata[i], exp_rdata);
    check({tag, " perr"}, {31'd0, perr[i]}, {31'd0, exp_err});
    we[i] = '0;
    re[i] = 1'b0;
  endtask

  task automatic idle_check(input int i, input string tag);
    @(negedge clk);
    check({tag, " ready pulse width"}, {31'd0, rdy[i]}, 32'd0);
  endtask

  initial begin
    // table: instance 0, READ_LATENCY=2, WRITE_LATENCY=1
    vecs[0] = '{1'b0, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF, 2, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b1, 4'b0000, 32'h0000_0010, 32'h0,         3, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 4'b1111, 32'h0000_0010, 32'h1122_3344, 2, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b0, 4'b0100, 32'h0000_0010, 32'hAAAA_AAAA, 2, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b1, 4'b0000, 32'h0000_0010, 32'h0,         3, 32'h11AA_3344, 1'b0};
    vecs[5] = '{1'b0, 4'b0011, 32'h0000_0010, 32'h0000_BEEF, 2, 32'h11AA_3344, 1'b0};
    vecs[6] = '{1'b1, 4'b0000, 32'h0000_0010, 32'h0,         3, 32'h11AA_BEEF, 1'b0};
    vecs[7] = '{1'b0, 4'b1111, 32'h0000_1000, 32'h0BAD_F00D, 2, 32'h11AA_BEEF, 1'b0};
    vecs[8] = '{1'b1, 4'b0000, 32'h0000_0000, 32'h0,         3, 32'h0BAD_F00D, 1'b0};
    vecs[9] = '{1'b1, 4'b0000, 32'h0000_0013, 32'h0,         3, 32'h11AA_BEEF, 1'b0};

    rst = 3'b111;
    re  = '0;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; wdata[i] = '0; we[i] = '0;
    end
    #2 rst = 3'b000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset rdata[%0d]", i), rdata[i], 32'd0);
      check($sformatf("reset ready[%0d]", i), {31'd0, rdy[i]}, 32'd0);
      check($sformatf("reset perr[%0d]", i), {31'd0, perr[i]}, 32'd0);
      check($sformatf("reset state[%0d]", i), 32'(st[i]), 32'(IDLE));
    end
    rst = 3'b111;
    @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      do_access(0, vecs[k].rd, vecs[k].w, vecs[k].a, vecs[k].d, vecs[k].cycles,
                vecs[k].exp_rdata, vecs[k].exp_err, $sformatf("vec%0d", k));
      idle_check(0, $sformatf("vec%0d", k));
    end

    // conflict: write wins, rdata unchanged, sticky error
    do_access(0, 1'b1, 4'b1111, 32'h0000_0014, 32'h5555_5555, 2, 32'h11AA_BEEF, 1'b1, "conflict");
    idle_check(0, "conflict");
    repeat (3) @(negedge clk);
    check("conflict sticky perr", {31'd0, perr[0]}, 32'd1);
    do_access(0, 1'b1, 4'b0000, 32'h0000_0014, 32'h0, 3, 32'h5555_5555, 1'b1, "conflict readback");
    idle_check(0, "conflict readback");

    // zero latency, including back-to-back reads
    do_access(1, 1'b0, 4'b1111, 32'h0000_0004, 32'h0101_0101, 1, 32'h0, 1'b0, "z wr1");
    idle_check(1, "z wr1");
    do_access(1, 1'b0, 4'b1111, 32'h0000_0008, 32'h0202_0202, 1, 32'h0, 1'b0, "z wr2");
    idle_check(1, "z wr2");
    do_access(1, 1'b1, 4'b0000, 32'h0000_0004, 32'h0, 1, 32'h0101_0101, 1'b0, "z rd1");
    do_access(1, 1'b1, 4'b0000, 32'h0000_0008, 32'h0, 2, 32'h0202_0202, 1'b0, "z b2b rd2");
    do_access(1, 1'b1, 4'b0000, 32'h0000_0004, 32'h0, 2, 32'h0101_0101, 1'b0, "z b2b rd1");
    idle_check(1, "z b2b rd1");
    check("z idle state", 32'(st[1]), 32'(IDLE));

    // reset mid-wait on a 4-cycle instance
    do_access(2, 1'b1, 4'b1111, 32'h0000_0020, 32'h8888_8888, 5, 32'h0, 1'b1, "r conflict");
    idle_check(2, "r conflict");
    do_access(2, 1'b0, 4'b1111, 32'h0000_001C, 32'h7777_7777, 5, 32'h0, 1'b1, "r wr7");
    idle_check(2, "r wr7");
    do_access(2, 1'b1, 4'b0000, 32'h0000_001C, 32'h0, 5, 32'h7777_7777, 1'b1, "r rd7");
    idle_check(2, "r rd7");
    addr[2] = 32'h0000_001C; wdata[2] = 32'hFFFF_FFFF; we[2] = 4'b1111;
    repeat (2) begin
      @(negedge clk);
      check("r pre-reset ready", {31'd0, rdy[2]}, 32'd0);
    end
    rst[2] = 1'b0;
    #1;
    check("r abort rdata", rdata[2], 32'd0);
    check("r abort perr", {31'd0, perr[2]}, 32'd0);
    check("r abort state", 32'(st[2]), 32'(IDLE));
    we[2] = '0;
    repeat (4) begin
      @(negedge clk);
      check("r abort ready", {31'd0, rdy[2]}, 32'd0);
    end
    rst[2] = 1'b1;
    @(negedge clk);
    do_access(2, 1'b1, 4'b0000, 32'h0000_001C, 32'h0, 5, 32'h7777_7777, 1'b0, "r rd7 after reset");
    idle_check(2, "r rd7 after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
